stream_rr_arbiter: RTL and testbench

- Round-robin, packet-aware arbiter that shares one downstream valid/ready stream among NUM_IN upstream requesters.
- Sits in front of shared datapath resources such as a single accelerator input port or a shared memory-write channel.
- Holds the grant for a whole packet, delimited by last, and registers the output through an internal 2-entry skid stage so that ready_out never combinationally reaches any ready_in.

---
 rtl/stream_rr_arbiter_if.sv | 30 +++
 rtl/stream_rr_arbiter.sv | 158 +++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_rr_arbiter_if.sv
// Stream bundle between NUM_IN upstream requesters, the arbiter and one downstream sink.
interface stream_rr_arbiter_if #(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [NUM_IN*DATA_WIDTH-1:0] data_in;
    logic [NUM_IN-1:0]            valid_in;
    logic [NUM_IN-1:0]            last_in;
    logic [NUM_IN-1:0]            ready_in;
    logic [DATA_WIDTH-1:0]        data_out;
    logic                         valid_out;
    logic                         last_out;
    logic                         ready_out;
    logic [IDX_W-1:0]             grant_idx;
    logic                         busy;

    // Environment side: drives requesters and the downstream ready.
    modport master (
        output data_in, valid_in, last_in, ready_out,
        input  ready_in, data_out, valid_out, last_out, grant_idx, busy
    );

    // Arbiter side.
    modport slave (
        input  data_in, valid_in, last_in, ready_out,
        output ready_in, data_out, valid_out, last_out, grant_idx, busy
    );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin arbiter: NUM_IN valid/ready streams onto one output through a
// 2-entry skid stage, so ready_out never reaches ready_in combinationally.
module stream_rr_arbiter #(
    parameter int unsigned NUM_IN      = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter bit          PACKET_MODE = 1'b1
) (
    input logic               clk,
    input logic               rst,
    stream_rr_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       grant_q, grant_d;

    logic                   main_valid_q, main_valid_d;
    logic [DATA_WIDTH-1:0]  main_data_q, main_data_d;
    logic                   main_last_q, main_last_d;
    logic                   ovf_valid_q, ovf_valid_d;
    logic [DATA_WIDTH-1:0]  ovf_data_q, ovf_data_d;
    logic                   ovf_last_q, ovf_last_d;

    logic                   skid_full;
    logic [NUM_IN-1:0]      ready_vec;
    logic                   push;
    logic                   pop;
    logic [DATA_WIDTH-1:0]  beat_data;
    logic                   beat_last;
    logic                   pick_found;
    logic [PTR_W-1:0]       pick_idx;
    logic [PTR_W-1:0]       cand;

    // Overflow is only ever occupied while main is, so full means both entries hold beats.
    assign skid_full = main_valid_q & ovf_valid_q;

    // First requesting index at or after rr_ptr, with wrap-around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            cand = PTR_W'((32'(rr_ptr_q) + i) % NUM_IN);
            if (!pick_found && bus.valid_in[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Only the grantee sees ready, and only from registered state.
    always_comb begin
        ready_vec = '0;
        if (state_q == StLocked) begin
            ready_vec[grant_q] = ~skid_full;
        end
    end

    assign push      = ready_vec[grant_q] & bus.valid_in[grant_q];
    assign pop       = main_valid_q & bus.ready_out;
    assign beat_data = bus.data_in[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign beat_last = bus.last_in[grant_q];

    // Grant FSM next state: one IDLE cycle of arbitration, then hold until release.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = StLocked;
                end
            end
            StLocked: begin
                if (push && (beat_last || !PACKET_MODE)) begin
                    state_d  = StIdle;
                    rr_ptr_d = (grant_q == PTR_W'(NUM_IN - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Skid stage next state: pop shifts overflow into main, push fills the first free entry.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_last_d  = main_last_q;
        ovf_valid_d  = ovf_valid_q;
        ovf_data_d   = ovf_data_q;
        ovf_last_d   = ovf_last_q;
        if (pop) begin
            if (ovf_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = ovf_data_q;
                main_last_d  = ovf_last_q;
                ovf_valid_d  = push;
                if (push) begin
                    ovf_data_d = beat_data;
                    ovf_last_d = beat_last;
                end
            end else begin
                main_valid_d = push;
                if (push) begin
                    main_data_d = beat_data;
                    main_last_d = beat_last;
                end
            end
        end else if (push) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = beat_data;
                main_last_d  = beat_last;
            end else begin
                ovf_valid_d = 1'b1;
                ovf_data_d  = beat_data;
                ovf_last_d  = beat_last;
            end
        end
    end

    // State registers; reset drops any in-flight packet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_last_q  <= 1'b0;
            ovf_valid_q  <= 1'b0;
            ovf_data_q   <= '0;
            ovf_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_last_q  <= main_last_d;
            ovf_valid_q  <= ovf_valid_d;
            ovf_data_q   <= ovf_data_d;
            ovf_last_q   <= ovf_last_d;
        end
    end

    assign bus.ready_in  = ready_vec;
    assign bus.data_out  = main_data_q;
    assign bus.valid_out = main_valid_q;
    assign bus.last_out  = main_last_q;
    assign bus.grant_idx = grant_q;
    assign bus.busy      = (state_q == StLocked) | main_valid_q;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: packet-mode and per-beat-mode instances.
module tb_stream_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stream_rr_arbiter_if #(.NUM_IN(4), .DATA_WIDTH(8)) bus ();
    stream_rr_arbiter_if #(.NUM_IN(4), .DATA_WIDTH(8)) bus0 ();

    stream_rr_arbiter #(.NUM_IN(4), .DATA_WIDTH(8), .PACKET_MODE(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    stream_rr_arbiter #(.NUM_IN(4), .DATA_WIDTH(8), .PACKET_MODE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int onehot_bad = 0;

    // Per-requester beat queues ({last, data}); main pushes, the source process pops.
    logic [8:0] srcmem [4][16];
    int wr [4] = '{default: 0};
    int rd [4] = '{default: 0};

    logic [8:0] outq [$];
    int         outc [$];
    logic [7:0] out0q [$];
    int         acc_cyc [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic push_beat(input int r, input logic [7:0] d, input logic l);
        srcmem[r][wr[r]] = {l, d};
        wr[r] = wr[r] + 1;
    endtask

    task automatic wait_out(input string tag, input int n, input int budget);
        int t = 0;
        while (outq.size() < n && t < budget) begin
            tick();
            t++;
        end
        check(tag, outq.size(), n);
    endtask

    function automatic logic [8:0] out_at(input int k);
        return (k < outq.size()) ? outq[k] : 9'h1ff;
    endfunction

    function automatic int outc_at(input int k);
        return (k < outc.size()) ? outc[k] : -100;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: values at the negedge are those present at the next rising edge.
    always @(negedge clk) begin
        if (bus.valid_out && bus.ready_out) begin
            outq.push_back({bus.last_out, bus.data_out});
            outc.push_back(cyc);
        end
        if (bus0.valid_out && bus0.ready_out) out0q.push_back(bus0.data_out);
        if ($countones(bus.ready_in) > 1) onehot_bad++;
    end

    // Upstream requesters of the packet-mode instance: hold a beat until it is accepted.
    initial begin
        logic [3:0] acc;
        bus.valid_in = '0;
        bus.data_in  = '0;
        bus.last_in  = '0;
        forever begin
            @(negedge clk);
            acc = bus.valid_in & bus.ready_in;
            if (acc != 4'b0) acc_cyc.push_back(cyc);
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) rd[i] = rd[i] + 1;
                if (rd[i] < wr[i]) begin
                    bus.valid_in[i]       = 1'b1;
                    bus.data_in[i*8 +: 8] = srcmem[i][rd[i]][7:0];
                    bus.last_in[i]        = srcmem[i][rd[i]][8];
                end else begin
                    bus.valid_in[i]       = 1'b0;
                    bus.data_in[i*8 +: 8] = 8'h00;
                    bus.last_in[i]        = 1'b0;
                end
            end
        end
    end

    initial begin
        int base;
        int t;
        bus.ready_out  = 1'b1;
        bus0.valid_in  = '0;
        bus0.data_in   = '0;
        bus0.last_in   = '0;
        bus0.ready_out = 1'b1;
        rst = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_valid_out", bus.valid_out, 0);
        check("rst_ready_in", bus.ready_in, 0);
        check("rst_grant_idx", bus.grant_idx, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_last_out", bus.last_out, 0);
        rst = 1'b1;
        tick();

        // Fairness: every requester holds two single-beat packets carrying its index
        outq.delete();
        outc.delete();
        for (int r = 0; r < 4; r++) begin
            push_beat(r, 8'(r), 1'b1);
            push_beat(r, 8'(r), 1'b1);
        end
        wait_out("fair_count", 8, 60);
        for (int k = 0; k < 8; k++) check("fair_data", out_at(k), 32'h100 | (k % 4));
        for (int k = 1; k < 8; k++) check("fair_gap", outc_at(k) - outc_at(k - 1), 2);
        tick();
        tick();

        // Packet lock: req0 three beats, req1 waits with one beat
        outq.delete();
        push_beat(0, 8'ha0, 1'b0);
        push_beat(0, 8'ha1, 1'b0);
        push_beat(0, 8'ha2, 1'b1);
        push_beat(1, 8'hb0, 1'b1);
        tick();
        tick();
        check("lock_grant0", bus.grant_idx, 0);
        check("lock_ready_a0", bus.ready_in, 4'b0001);
        tick();
        check("lock_ready_a1", bus.ready_in, 4'b0001);
        tick();
        check("lock_ready_a2", bus.ready_in, 4'b0001);
        tick();
        check("lock_release_ready", bus.ready_in, 4'b0000);
        check("lock_release_busy", bus.busy, 1);
        tick();
        check("lock_grant1", bus.grant_idx, 1);
        check("lock_ready_b0", bus.ready_in, 4'b0010);
        wait_out("lock_count", 4, 20);
        check("lock_out0", out_at(0), 9'h0a0);
        check("lock_out1", out_at(1), 9'h0a1);
        check("lock_out2", out_at(2), 9'h1a2);
        check("lock_out3", out_at(3), 9'h1b0);
        tick();

        // Backpressure: ready_out low for 5 cycles during a 4-beat packet from req2
        outq.delete();
        bus.ready_out = 1'b0;
        base = wr[2];
        push_beat(2, 8'hc0, 1'b0);
        push_beat(2, 8'hc1, 1'b0);
        push_beat(2, 8'hc2, 1'b0);
        push_beat(2, 8'hc3, 1'b1);
        tick();
        tick();
        check("bp_grant2", bus.grant_idx, 2);
        check("bp_ready_first", bus.ready_in, 4'b0100);
        tick();
        check("bp_ready_one_held", bus.ready_in, 4'b0100);
        tick();
        check("bp_ready_full", bus.ready_in, 4'b0000);
        check("bp_valid_out", bus.valid_out, 1);
        check("bp_data_hold", bus.data_out, 8'hc0);
        tick();
        check("bp_ready_still_full", bus.ready_in, 4'b0000);
        check("bp_data_stable", bus.data_out, 8'hc0);
        check("bp_accepted", rd[2] - base, 2);
        bus.ready_out = 1'b1;
        wait_out("bp_count", 4, 20);
        check("bp_out0", out_at(0), 9'h0c0);
        check("bp_out1", out_at(1), 9'h0c1);
        check("bp_out2", out_at(2), 9'h0c2);
        check("bp_out3", out_at(3), 9'h1c3);
        tick();

        // Full throughput: one 8-beat packet from req3
        outq.delete();
        outc.delete();
        acc_cyc.delete();
        for (int k = 0; k < 8; k++) push_beat(3, 8'(8'h30 + k), (k == 7));
        wait_out("thru_count", 8, 30);
        for (int k = 0; k < 8; k++) check("thru_data", out_at(k), (k == 7 ? 32'h100 : 0) | (32'h30 + k));
        check("thru_latency", outc_at(0) - ((acc_cyc.size() > 0) ? acc_cyc[0] : -100), 1);
        for (int k = 1; k < 8; k++) check("thru_gap", outc_at(k) - outc_at(k - 1), 1);
        tick();

        // Per-beat arbitration: req2 and req3 stream last=0 beats
        bus0.data_in  = {8'h33, 8'h22, 8'h00, 8'h00};
        bus0.valid_in = 4'b1100;
        t = 0;
        while (out0q.size() < 4 && t < 30) begin
            tick();
            t++;
        end
        bus0.valid_in = 4'b0000;
        check("pm0_count", (out0q.size() >= 4), 1);
        for (int k = 0; k < 4; k++)
            check("pm0_data", (k < out0q.size()) ? out0q[k] : 8'hff, (k % 2 == 0) ? 8'h22 : 8'h33);
        tick();

        // Reset mid-packet: req1 4-beat packet, reset after 2 beats accepted
        outq.delete();
        base = wr[1];
        push_beat(1, 8'hd0, 1'b0);
        push_beat(1, 8'hd1, 1'b0);
        push_beat(1, 8'hd2, 1'b0);
        push_beat(1, 8'hd3, 1'b1);
        t = 0;
        while (rd[1] - base < 2 && t < 20) begin
            tick();
            t++;
        end
        check("mid_two_accepted", rd[1] - base, 2);
        rst = 1'b0;
        #1;
        check("mid_valid_out", bus.valid_out, 0);
        check("mid_ready_in", bus.ready_in, 4'b0000);
        check("mid_grant_idx", bus.grant_idx, 0);
        check("mid_busy", bus.busy, 0);
        wr[1] = rd[1];
        tick();
        rst = 1'b1;
        push_beat(2, 8'he2, 1'b1);
        push_beat(3, 8'he3, 1'b1);
        tick();
        tick();
        check("mid_regrant", bus.grant_idx, 2);
        check("mid_regrant_ready", bus.ready_in, 4'b0100);
        wait_out("mid_count", 3, 20);
        check("mid_out0", out_at(0), 9'h0d0);
        check("mid_out1", out_at(1), 9'h1e2);
        check("mid_out2", out_at(2), 9'h1e3);

        check("ready_onehot", onehot_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
